fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch engine with a small in-order instruction buffer.
//
// Issues one word read at a time on the instruction bus, buffers the returned
// words together with their addresses, and hands them to the core through a
// valid/ready interface. A core redirect flushes the buffer and restarts
// fetching at the new PC; a read that was already on the bus when the
// redirect arrived has its data dropped. A misaligned redirect target sets a
// sticky error that stops fetching until an aligned redirect or reset.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ibus_ss, ibus_bstart          slave select, one-cycle transfer start
//   ibus_addr                     word-aligned read address
//   ibus_tsize, ibus_ttype        constant WORD / READ
//   ibus_rdata, ibus_bdone        read data, valid in the bdone cycle
//   redirect, redirect_pc         core-requested PC change
//   instr_valid, instr_ready      buffer head handshake
//   instr, instr_pc               buffer head word and its address
//   fetch_err                     sticky misaligned-redirect flag

package fetch_unit_pkg;
    typedef enum logic [1:0] {
        TSIZE_BYTE = 2'b00,
        TSIZE_HALF = 2'b01,
        TSIZE_WORD = 2'b10
    } tsize_e;

    typedef enum logic {
        TTYPE_READ  = 1'b0,
        TTYPE_WRITE = 1'b1
    } ttype_e;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_ss,
    output logic        ibus_bstart,
    output logic [31:0] ibus_addr,
    output tsize_e      ibus_tsize,
    output ttype_e      ibus_ttype,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_bdone,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        addr_q;
    logic               inflight;
    logic               discard;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [31:0]        buf_pc   [DEPTH];
    logic [31:0]        buf_data [DEPTH];

    logic push;
    logic pop;
    logic room;
    logic space_next;
    logic err_next;

    always_comb begin
        pop        = (count != '0) && instr_ready && !redirect;
        // A response is kept only if no redirect is pending or coincident.
        push       = (state == S_WAIT) && ibus_bdone && !discard && !redirect;
        count_next = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
        room       = ((CNT_W + 1)'(count) + (CNT_W + 1)'(inflight)) < DEPTH_C;
        space_next = (CNT_W + 1)'(count_next) < DEPTH_C;
        err_next   = redirect ? (redirect_pc[1:0] != 2'b00) : fetch_err;
    end

    // Bus outputs decode the registered state; the address is frozen while
    // waiting so a redirect cannot disturb the transfer in progress.
    assign ibus_ss     = (state != S_IDLE);
    assign ibus_bstart = (state == S_ISSUE);
    assign ibus_addr   = (state == S_WAIT) ? addr_q : fetch_pc;
    assign ibus_tsize  = TSIZE_WORD;
    assign ibus_ttype  = TTYPE_READ;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? buf_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            addr_q    <= RESET_PC;
            inflight  <= 1'b0;
            discard   <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= err_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end
            unique case (state)
                S_IDLE: begin
                    // A redirect empties the buffer, so space is guaranteed.
                    if ((redirect || room) && !err_next) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    addr_q   <= fetch_pc;
                    inflight <= 1'b1;
                    state    <= S_WAIT;
                    if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ibus_bdone) begin
                        inflight <= 1'b0;
                        discard  <= 1'b0;
                        if (!redirect && !discard) begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                        state <= (space_next && !err_next) ? S_ISSUE : S_IDLE;
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]   <= addr_q;
                buf_data[wr_ptr] <= ibus_rdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
//
// A transaction-level model tracks the outstanding read, whether a redirect
// has made it stale, the queue of words the core should see and the sticky
// error; it is compared against the DUT every cycle. Directed scenarios pin
// exact cycle timing and addresses, then a randomized run exercises redirects,
// misaligned targets, bus latency, spurious bdone pulses and resets.

module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ibus_ss, ibus_bstart, ibus_bdone;
    logic [31:0] ibus_addr, ibus_rdata;
    tsize_e      ibus_tsize;
    ttype_e      ibus_ttype;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready, fetch_err;
    logic [31:0] instr, instr_pc;

    initial begin
        ibus_bdone  = 1'b0;
        ibus_rdata  = '0;
        instr_ready = 1'b0;
    end

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ibus_ss(ibus_ss), .ibus_bstart(ibus_bstart), .ibus_addr(ibus_addr),
        .ibus_tsize(ibus_tsize), .ibus_ttype(ibus_ttype),
        .ibus_rdata(ibus_rdata), .ibus_bdone(ibus_bdone),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fetch_err(fetch_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned n_bs     = 0;

    // Inputs to apply in the next cycle (redirect and force_bdone are one-shot).
    logic        nxt_rst = 1'b1, nxt_rd = 1'b0, nxt_ready = 1'b1, force_bdone = 1'b0;
    logic [31:0] nxt_rpc = '0;
    logic        spur_en = 1'b0;
    int unsigned lat_min = 1, lat_max = 1;

    // Outputs sampled in the most recent cycle.
    logic        s_ss, s_bstart, s_valid, s_err;
    logic [31:0] s_addr, s_instr, s_pc;

    // Reference model state.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_data[$];
    logic        m_out = 1'b0, m_stale = 1'b0, m_err = 1'b0, m_reset = 1'b1;
    logic [31:0] m_fetch = RESET_PC, m_out_addr = '0;
    int unsigned slave_cnt = 0, starve = 0;

    task automatic chk(input logic ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic        bd;
        logic [31:0] rdat, pre;
        @(negedge clk);
        cyc++;
        s_ss = ibus_ss; s_bstart = ibus_bstart; s_addr = ibus_addr;
        s_valid = instr_valid; s_instr = instr; s_pc = instr_pc; s_err = fetch_err;
        if (s_bstart) n_bs++;

        chk(ibus_tsize == TSIZE_WORD, "tsize", 32'(ibus_tsize), 32'(TSIZE_WORD));
        chk(ibus_ttype == TTYPE_READ, "ttype", 32'(ibus_ttype), 32'(TTYPE_READ));
        chk(s_err == m_err, "fetch_err", 32'(s_err), 32'(m_err));
        chk(s_ss == (m_out | s_bstart), "ibus_ss", 32'(s_ss), 32'(m_out | s_bstart));
        if (s_bstart) begin
            chk(!m_out, "bstart_while_busy", 32'(s_bstart), 32'd0);
            chk(!m_err, "bstart_while_err", 32'(s_bstart), 32'd0);
            chk(s_addr == m_fetch, "bstart_addr", s_addr, m_fetch);
        end
        if (m_out) chk(s_addr == m_out_addr, "addr_hold", s_addr, m_out_addr);
        chk(s_valid == (mq_pc.size() != 0), "instr_valid", 32'(s_valid), 32'(mq_pc.size() != 0));
        if (s_valid && mq_pc.size() != 0) begin
            chk(s_pc == mq_pc[0], "instr_pc", s_pc, mq_pc[0]);
            chk(s_instr == mq_data[0], "instr", s_instr, mq_data[0]);
        end
        if (m_reset) begin
            chk(s_instr == '0, "reset_instr", s_instr, '0);
            chk(s_pc == '0, "reset_instr_pc", s_pc, '0);
            chk(s_addr == RESET_PC, "reset_addr", s_addr, RESET_PC);
        end
        // With room, no error and nothing outstanding, at most one idle cycle.
        if (nxt_rst || m_err || m_out || s_bstart || mq_pc.size() >= DEPTH) starve = 0;
        else starve++;
        chk(starve <= 1, "fetch_stall", starve, 32'd1);

        // Memory slave.
        bd = 1'b0;
        if (slave_cnt != 0) begin
            slave_cnt--;
            if (slave_cnt == 0) bd = 1'b1;
        end
        if (s_bstart) slave_cnt = $urandom_range(lat_max, lat_min);
        if (!s_ss && spur_en && $urandom_range(9, 0) == 0) bd = 1'b1;
        if (nxt_rst) slave_cnt = 0;
        if (force_bdone) bd = 1'b1;
        rdat = $urandom;

        rst = nxt_rst; redirect = nxt_rd; redirect_pc = nxt_rpc;
        instr_ready = nxt_ready; ibus_bdone = bd; ibus_rdata = rdat;

        // Model update for the coming edge.
        pre = m_fetch;
        if (nxt_rst) begin
            mq_pc.delete(); mq_data.delete();
            m_out = 1'b0; m_stale = 1'b0; m_err = 1'b0; m_fetch = RESET_PC; m_reset = 1'b1;
        end else begin
            m_reset = 1'b0;
            if (mq_pc.size() != 0 && nxt_ready && !nxt_rd) begin
                void'(mq_pc.pop_front());
                void'(mq_data.pop_front());
            end
            if (m_out && bd) begin
                m_out = 1'b0;
                if (!m_stale && !nxt_rd) begin
                    mq_pc.push_back(m_out_addr);
                    mq_data.push_back(rdat);
                    m_fetch = m_fetch + 32'd4;
                    chk(mq_pc.size() <= DEPTH, "buffer_overflow", mq_pc.size(), DEPTH);
                end
            end
            if (nxt_rd) begin
                mq_pc.delete(); mq_data.delete();
                m_fetch = nxt_rpc;
                m_err   = (nxt_rpc[1:0] != 2'b00);
                if (m_out) m_stale = 1'b1;
            end
            if (s_bstart) begin
                m_out = 1'b1; m_out_addr = pre; m_stale = nxt_rd;
            end
        end
        nxt_rd = 1'b0;
        force_bdone = 1'b0;
    endtask

    task automatic wait_bstart(input int unsigned maxc, output logic found,
                               output logic [31:0] a);
        found = 1'b0;
        a = '0;
        for (int unsigned i = 0; i < maxc && !found; i++) begin
            cycle();
            if (s_bstart) begin found = 1'b1; a = s_addr; end
        end
        chk(found, "bstart_timeout", 32'(found), 32'd1);
    endtask

    task automatic do_reset();
        nxt_rst = 1'b1;
        cycle();
        nxt_rst = 1'b0;
    endtask

    int unsigned bs_k[8], nb, np;
    logic [31:0] bs_a[8], pop_pc[8];
    logic        found;
    logic [31:0] a;

    initial begin
        cycle();
        cycle();

        // Back-to-back fetch with 1-cycle slave and a ready core.
        nxt_rst = 1'b0; nxt_ready = 1'b1; nb = 0; np = 0;
        for (int unsigned k = 1; k <= 9; k++) begin
            cycle();
            if (s_bstart && nb < 8) begin bs_k[nb] = k; bs_a[nb] = s_addr; nb++; end
            if (s_valid && np < 8) begin pop_pc[np] = s_pc; np++; end
        end
        chk(nb >= 3, "t1_bstart_count", nb, 32'd3);
        chk(np >= 3, "t1_pop_count", np, 32'd3);
        for (int unsigned i = 0; i < 3; i++) begin
            chk(bs_k[i] == 2 + 2 * i, "t1_bstart_cycle", bs_k[i], 2 + 2 * i);
            chk(bs_a[i] == 4 * i, "t1_bstart_addr", bs_a[i], 4 * i);
            chk(pop_pc[i] == 4 * i, "t1_instr_pc", pop_pc[i], 4 * i);
        end

        // Stalled core: buffer fills with two words, then fetching stops.
        nxt_ready = 1'b0;
        do_reset();
        nb = 0;
        for (int unsigned k = 1; k <= 10; k++) begin
            cycle();
            if (s_bstart && nb < 8) begin bs_a[nb] = s_addr; nb++; end
        end
        chk(nb == 2, "t2_fetch_count", nb, 32'd2);
        chk(bs_a[0] == 32'h0, "t2_addr0", bs_a[0], 32'h0);
        chk(bs_a[1] == 32'h4, "t2_addr1", bs_a[1], 32'h4);
        chk(!s_ss, "t2_idle_ss", 32'(s_ss), 32'd0);
        nxt_ready = 1'b1;
        cycle();
        chk(s_valid && s_pc == 32'h0, "t2_pop_pc", s_pc, 32'h0);
        nxt_ready = 1'b0; nb = 0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cycle();
            if (s_bstart && nb < 8) begin bs_k[nb] = k; bs_a[nb] = s_addr; nb++; end
        end
        chk(nb == 1 && bs_k[0] == 2, "t2_refetch_cycle", bs_k[0], 32'd2);
        chk(bs_a[0] == 32'h8, "t2_refetch_addr", bs_a[0], 32'h8);

        // Redirect while waiting on the read of address 4.
        lat_min = 3; lat_max = 3;
        do_reset();
        found = 1'b0;
        for (int unsigned k = 0; k < 20 && !found; k++) begin
            cycle();
            found = s_bstart && (s_addr == 32'h4);
        end
        chk(found, "t3_addr4_timeout", 32'(found), 32'd1);
        nxt_rd = 1'b1; nxt_rpc = 32'h100;
        cycle();
        cycle();
        chk(!s_valid, "t3_flush", 32'(s_valid), 32'd0);
        wait_bstart(10, found, a);
        chk(a == 32'h100, "t3_redirect_addr", a, 32'h100);
        nxt_ready = 1'b1; found = 1'b0;
        for (int unsigned k = 0; k < 20 && !found; k++) begin
            cycle();
            found = s_valid;
        end
        chk(found && s_pc == 32'h100, "t3_first_pc", s_pc, 32'h100);

        // Misaligned redirect blocks fetching until an aligned one.
        lat_min = 1; lat_max = 1;
        nxt_rd = 1'b1; nxt_rpc = 32'h102;
        cycle();
        nb = 0;
        for (int unsigned k = 0; k < 8; k++) begin
            cycle();
            if (s_bstart) nb++;
        end
        chk(nb == 0, "t4_no_fetch", nb, 32'd0);
        chk(s_err, "t4_err_set", 32'(s_err), 32'd1);
        nxt_rd = 1'b1; nxt_rpc = 32'h200;
        cycle();
        wait_bstart(4, found, a);
        chk(a == 32'h200, "t4_recover_addr", a, 32'h200);
        chk(!s_err, "t4_err_clear", 32'(s_err), 32'd0);

        // Fetch PC wraps through zero.
        nxt_rd = 1'b1; nxt_rpc = 32'hFFFF_FFFC;
        cycle();
        wait_bstart(10, found, a);
        chk(a == 32'hFFFF_FFFC, "t5_wrap_first", a, 32'hFFFF_FFFC);
        wait_bstart(10, found, a);
        chk(a == 32'h0, "t5_wrap_second", a, 32'h0);

        // Reset mid-transfer, late bdone right after release.
        do_reset();
        wait_bstart(4, found, a);
        nxt_rst = 1'b1;
        cycle();
        nxt_rst = 1'b0; force_bdone = 1'b1;
        cycle();
        chk(!s_valid, "t6_valid_in_reset", 32'(s_valid), 32'd0);
        cycle();
        chk(!s_valid, "t6_valid_after_stale_bdone", 32'(s_valid), 32'd0);
        chk(s_bstart && s_addr == RESET_PC, "t6_refetch", s_addr, RESET_PC);
        cycle();
        chk(!s_valid, "t6_valid_waiting", 32'(s_valid), 32'd0);
        cycle();
        chk(s_valid && s_pc == RESET_PC, "t6_first_instr", s_pc, RESET_PC);

        // Randomized run.
        lat_min = 1; lat_max = 3; spur_en = 1'b1; n_bs = 0;
        for (int unsigned k = 0; k < 3000; k++) begin
            int unsigned r;
            r = $urandom_range(199, 0);
            nxt_ready = ($urandom_range(9, 0) < 7);
            nxt_rst = (r == 0);
            if (r >= 1 && r <= 6) begin
                nxt_rd = 1'b1; nxt_rpc = $urandom & 32'hFFFF_FFFC;
            end else if (r == 7) begin
                nxt_rd = 1'b1; nxt_rpc = $urandom | 32'h1;
            end else if (r == 8) begin
                nxt_rd = 1'b1; nxt_rpc = 32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4);
            end
            cycle();
        end
        nxt_rst = 1'b0;
        cycle();
        chk(n_bs > 300, "random_progress", n_bs, 32'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
